// File: rtl/pio_sweep_pkg.sv
// pio_sweep_pkg: PIO register map and sequencer FSM states shared by the sweep sequencer.
package pio_sweep_pkg;

    localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE    = 3'd3;
    localparam logic [2:0] PIO_ADDR_SET     = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLR     = 3'd5;

    // STEP_SET is only reached in the set/clear build
    typedef enum logic [2:0] {
        INIT_MASK,
        INIT_DATA,
        RUN,
        IRQ_READ,
        IRQ_WAIT,
        IRQ_CLEAR,
        STEP_WRITE,
        STEP_SET
    } state_e;

endpackage

// File: rtl/sweep_tick_gen.sv
// sweep_tick_gen: free-running 0..TICK_DIV-1 step counter that holds when run is low
// and pulses wrap for the single cycle it rolls over.
module sweep_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic wrap
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = run && (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = !run ? cnt_q : (wrap ? '0 : cnt_q + CW'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pio_sweep_sequencer.sv
// pio_sweep_sequencer: Avalon-MM master ping-ponging a one-hot LED over a PIO and servicing
// its button edge-capture irq. Define SWEEP_SETCLR_EN to step via the set/clear registers.
module pio_sweep_sequencer
    import pio_sweep_pkg::*;
#(
    parameter int LED_WIDTH     = 8,
    parameter int TICK_DIV      = 5000000,
    parameter int BTN_PAUSE_BIT = 0,
    parameter int BTN_DIR_BIT   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    output logic [2:0]                   avm_address,
    output logic                         avm_chipselect,
    output logic                         avm_write_n,
    output logic [31:0]                  avm_writedata,
    input  logic [31:0]                  avm_readdata,
    input  logic                         pio_irq,
    output logic [$clog2(LED_WIDTH)-1:0] led_pos,
    output logic                         sweep_dir,
    output logic                         paused
);

    localparam int              PW       = $clog2(LED_WIDTH);
    localparam logic [PW-1:0]   LAST     = PW'(LED_WIDTH - 1);
    localparam logic [31:0]     IRQ_MASK = (32'd1 << BTN_PAUSE_BIT) | (32'd1 << BTN_DIR_BIT);

    state_e        state_q, state_d;
    logic          armed_q;
    logic [PW-1:0] pos_q, pos_d, step_pos;
    logic          dir_q, dir_d, step_dir, at_end;
    logic          paused_q, paused_d;
    logic          pend_q, pend_d;
    logic [31:0]   cap_q, cap_d;
    logic          tick_run, wrap;

    // The counter keeps running through IRQ service so a wrap there is remembered as pending
    assign tick_run = armed_q && state_q != INIT_MASK && state_q != INIT_DATA && enable && !paused_q;

    sweep_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (tick_run),
        .wrap    (wrap)
    );

    always_comb begin
        at_end   = dir_q ? (pos_q == '0) : (pos_q == LAST);
        step_dir = at_end ? ~dir_q : dir_q;
        step_pos = step_dir ? pos_q - PW'(1) : pos_q + PW'(1);
    end

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        dir_d          = dir_q;
        paused_d       = paused_q;
        cap_d          = cap_q;
        pend_d         = pend_q | wrap;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = PIO_ADDR_DATA;
        avm_writedata  = '0;
        case (state_q)
            INIT_MASK: begin
                // armed_q keeps the strobe off until the first clock after reset release
                if (armed_q) begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = PIO_ADDR_IRQMASK;
                    avm_writedata  = IRQ_MASK;
                    state_d        = INIT_DATA;
                end
            end
            INIT_DATA: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
`ifdef SWEEP_SETCLR_EN
                avm_address    = PIO_ADDR_SET;
`else
                avm_address    = PIO_ADDR_DATA;
`endif
                avm_writedata  = 32'd1;
                state_d        = RUN;
            end
            RUN: state_d = pio_irq ? IRQ_READ : ((pend_q && enable) ? STEP_WRITE : RUN);
            IRQ_READ: begin
                avm_chipselect = 1'b1;
                avm_address    = PIO_ADDR_EDGE;
                state_d        = IRQ_WAIT;
            end
            IRQ_WAIT: begin
                cap_d   = avm_readdata;
                state_d = IRQ_CLEAR;
            end
            IRQ_CLEAR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_ADDR_EDGE;
                avm_writedata  = cap_q;
                paused_d       = paused_q ^ cap_q[BTN_PAUSE_BIT];
                dir_d          = dir_q ^ cap_q[BTN_DIR_BIT];
                pend_d         = (paused_d && !paused_q) ? 1'b0 : pend_d;
                state_d        = RUN;
            end
            STEP_WRITE: begin
                pos_d          = step_pos;
                dir_d          = step_dir;
                pend_d         = 1'b0;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
`ifdef SWEEP_SETCLR_EN
                avm_address    = PIO_ADDR_CLR;
                avm_writedata  = 32'd1 << pos_q;
                state_d        = STEP_SET;
`else
                avm_address    = PIO_ADDR_DATA;
                avm_writedata  = 32'd1 << step_pos;
                state_d        = RUN;
`endif
            end
            STEP_SET: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_ADDR_SET;
                avm_writedata  = 32'd1 << pos_q;
                state_d        = RUN;
            end
            default: state_d = INIT_MASK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT_MASK;
            armed_q  <= 1'b0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            paused_q <= 1'b0;
            pend_q   <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            pend_q   <= pend_d;
            cap_q    <= cap_d;
        end
    end

    assign led_pos   = pos_q;
    assign sweep_dir = dir_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_pio_sweep_sequencer.sv
// tb_pio_sweep_sequencer: scoreboard bench with a small PIO model (irq mask, edge capture,
// registered readdata); expected bus transactions are queued as stimulus is applied.
module tb_pio_sweep_sequencer;

    typedef struct packed {
        logic [2:0]  a;
        logic        wn;
        logic [31:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        pio_irq;
    logic [1:0]  led_pos;
    logic        sweep_dir;
    logic        paused;

    logic [1:0]  btn = 2'b00;
    logic [31:0] edge_cap, irq_mask;
    txn_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          last_d0 = 0, n_d0 = 0, mask_cyc = 0, rd_cyc = 0, clr_cyc = 0;
    bit          gap_en = 1'b1;

    pio_sweep_sequencer #(.LED_WIDTH(4), .TICK_DIV(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .pio_irq        (pio_irq),
        .led_pos        (led_pos),
        .sweep_dir      (sweep_dir),
        .paused         (paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap     <= '0;
            irq_mask     <= '0;
            avm_readdata <= '0;
        end else begin
            edge_cap <= (edge_cap | {30'd0, btn}) &
                        ~((avm_chipselect && !avm_write_n && avm_address == 3'd3) ? avm_writedata : 32'd0);
            if (avm_chipselect && !avm_write_n && avm_address == 3'd2) irq_mask <= avm_writedata;
            avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 3'd3) ? edge_cap : 32'd0;
        end
    end

    assign pio_irq = |(edge_cap & irq_mask);

    function automatic txn_t wr(logic [2:0] a, logic [31:0] d);
        return '{a: a, wn: 1'b0, d: d};
    endfunction

    function automatic txn_t rd3();
        return '{a: 3'd3, wn: 1'b1, d: 32'd0};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (avm_chipselect === 1'b1) begin
                txn_t got;
                got = '{a: avm_address, wn: avm_write_n, d: avm_write_n ? 32'd0 : avm_writedata};
                if (exp_q.size() == 0) check("unexpected_txn", 64'({1'b1, got}), 64'd0);
                else check("txn", 64'(got), 64'(exp_q.pop_front()));
                if (!avm_write_n && avm_address == 3'd2) mask_cyc = cyc;
                if (avm_write_n && avm_address == 3'd3) rd_cyc = cyc;
                if (!avm_write_n && avm_address == 3'd3) clr_cyc = cyc;
                if (!avm_write_n && avm_address == 3'd0) begin
                    if (n_d0 == 0) check("init_b2b", 64'(cyc - mask_cyc), 64'd1);
                    else if (gap_en && n_d0 >= 2) check("step_gap", 64'(cyc - last_d0), 64'd4);
                    last_d0 = cyc;
                    n_d0++;
                end
            end
        end
    endtask

    task automatic wait_q(int n, int budget, string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = exp_q.size() <= n;
        end
        if (!ok) check(tag, 64'(exp_q.size()), 64'(n));
    endtask

    task automatic press(logic [1:0] bits);
        btn = bits;
        @(posedge clk);
        #2 btn = 2'b00;
    endtask

    initial begin
        fork
            monitor();
        join_none
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs", 64'(avm_chipselect), 64'd0);
        check("rst_wn", 64'(avm_write_n), 64'd1);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_wd", 64'(avm_writedata), 64'd0);
        check("rst_pos", 64'(led_pos), 64'd0);
        check("rst_dir", 64'(sweep_dir), 64'd0);
        check("rst_paused", 64'(paused), 64'd0);

        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(wr(3'd2, 32'h3));
        exp_q.push_back(wr(3'd0, 32'h1));
        exp_q.push_back(wr(3'd0, 32'h2));
        exp_q.push_back(wr(3'd0, 32'h4));
        exp_q.push_back(wr(3'd0, 32'h8));
        exp_q.push_back(wr(3'd0, 32'h4));
        exp_q.push_back(wr(3'd0, 32'h2));
        exp_q.push_back(wr(3'd0, 32'h1));
        exp_q.push_back(wr(3'd0, 32'h2));
        reset_n = 1'b1;
        wait_q(3, 100, "bounce_top_timeout");
        check("bounce_top_dir", 64'(sweep_dir), 64'd1);
        check("bounce_top_pos", 64'(led_pos), 64'd2);
        wait_q(0, 100, "sweep_timeout");
        check("bounce_bot_dir", 64'(sweep_dir), 64'd0);
        check("bounce_bot_pos", 64'(led_pos), 64'd1);
        gap_en = 1'b0;

        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h1));
        press(2'b01);
        wait_q(0, 50, "pause_timeout");
        check("pause_on", 64'(paused), 64'd1);
        check("irq_3cyc", 64'(clr_cyc - rd_cyc), 64'd2);
        repeat (20) @(posedge clk);
        #2;
        check("pause_hold_pos", 64'(led_pos), 64'd1);

        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h1));
        exp_q.push_back(wr(3'd0, 32'h4));
        press(2'b01);
        wait_q(0, 50, "resume_timeout");
        check("resume_paused", 64'(paused), 64'd0);
        check("resume_pos", 64'(led_pos), 64'd2);

        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h3));
        press(2'b11);
        wait_q(0, 50, "both_timeout");
        check("both_paused", 64'(paused), 64'd1);
        check("both_dir", 64'(sweep_dir), 64'd1);
        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h1));
        exp_q.push_back(wr(3'd0, 32'h2));
        press(2'b01);
        wait_q(0, 50, "unpause_timeout");
        check("unpause_pos", 64'(led_pos), 64'd1);
        check("unpause_paused", 64'(paused), 64'd0);

        // irq timed so IRQ_READ lands on the cycle of a tick wrap
        exp_q.push_back(wr(3'd0, 32'h1));
        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h2));
        exp_q.push_back(wr(3'd0, 32'h2));
        repeat (3) @(posedge clk);
        #2;
        press(2'b10);
        wait_q(0, 50, "wrap_irq_timeout");
        enable = 1'b0;
        check("clr_to_step", 64'(last_d0 - clr_cyc), 64'd2);
        repeat (8) @(posedge clk);
        #2;
        check("wrap_irq_pos", 64'(led_pos), 64'd1);
        check("wrap_irq_dir", 64'(sweep_dir), 64'd0);

        exp_q.push_back(rd3());
        exp_q.push_back(wr(3'd3, 32'h2));
        press(2'b10);
        wait_q(0, 50, "dis_irq_timeout");
        repeat (10) @(posedge clk);
        #2;
        check("dis_dir", 64'(sweep_dir), 64'd1);
        check("dis_pos", 64'(led_pos), 64'd1);

        exp_q.push_back(rd3());
        press(2'b01);
        wait_q(0, 50, "rst_irq_timeout");
        reset_n = 1'b0;
        #1;
        check("arst_cs", 64'(avm_chipselect), 64'd0);
        check("arst_wn", 64'(avm_write_n), 64'd1);
        check("arst_pos", 64'(led_pos), 64'd0);
        check("arst_dir", 64'(sweep_dir), 64'd0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        exp_q.push_back(wr(3'd2, 32'h3));
        exp_q.push_back(wr(3'd0, 32'h1));
        reset_n = 1'b1;
        wait_q(0, 50, "reinit_timeout");
        check("reinit_pos", 64'(led_pos), 64'd0);
        check("reinit_paused", 64'(paused), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
